// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial N-bit adder controller driving an external 1-bit full adder,
// LSB first, with the adder's carry-out registered back as the next carry-in.
module serial_add_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         add_a,
  output logic         add_b,
  output logic         add_ci,
  input  logic         add_sum,
  input  logic         add_co
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state;
  logic [N-1:0]   a_sr, b_sr, result_sr, sum_next;
  logic           carry_r;
  logic [CW-1:0]  cnt;
  assign sum_next = {add_sum, result_sr[N-1:1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      result_sr <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          a_sr      <= a_in;
          b_sr      <= b_in;
          carry_r   <= cin;
          cnt       <= '0;
          result_sr <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          result_sr <= sum_next;
          carry_r   <= add_co;
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            result <= sum_next;
            cout   <= add_co;
          end else
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
  // adder inputs come only from registers, breaking the loop through the external adder
  always_comb begin
    busy   = state != IDLE;
    done   = state == DONE;
    add_a  = state == SHIFT ? a_sr[0] : 1'b0;
    add_b  = state == SHIFT ? b_sr[0] : 1'b0;
    add_ci = state == SHIFT ? carry_r : 1'b0;
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed vectors into N=8 and N=2 instances, each closed around a
// behavioural full adder; expected sums are queued at issue and popped by done-driven monitors.
module tb_serial_add_sequencer;
  logic clk = 0, rst = 1;
  logic start8 = 0, cin8 = 0, start2 = 0, cin2 = 0;
  logic [7:0] a_in8 = 0, b_in8 = 0, result8;
  logic [1:0] a_in2 = 0, b_in2 = 0, result2;
  logic busy8, done8, cout8, add_a8, add_b8, add_ci8, add_sum8, add_co8;
  logic busy2, done2, cout2, add_a2, add_b2, add_ci2, add_sum2, add_co2;
  int cmp = 0, err = 0, cyc = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int dq8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign add_sum8 = add_a8 ^ add_b8 ^ add_ci8;
  assign add_co8  = (add_a8 & add_b8) | (add_ci8 & (add_a8 ^ add_b8));
  assign add_sum2 = add_a2 ^ add_b2 ^ add_ci2;
  assign add_co2  = (add_a2 & add_b2) | (add_ci2 & (add_a2 ^ add_b2));

  serial_add_sequencer #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a_in8), .b_in(b_in8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8),
    .add_a(add_a8), .add_b(add_b8), .add_ci(add_ci8), .add_sum(add_sum8), .add_co(add_co8));

  serial_add_sequencer #(.N(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a_in2), .b_in(b_in2), .cin(cin2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2),
    .add_a(add_a2), .add_b(add_b2), .add_ci(add_ci2), .add_sum(add_sum2), .add_co(add_co2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst && done8) begin
    logic [8:0] e;
    dq8.push_back(cyc);
    if (q8.size() == 0) chk("unexpected_done8", 1, 0);
    else begin
      e = q8.pop_front();
      chk("sum8", {55'd0, cout8, result8}, {55'd0, e});
    end
  end

  always @(negedge clk) if (!rst && done2) begin
    logic [2:0] e;
    if (q2.size() == 0) chk("unexpected_done2", 1, 0);
    else begin
      e = q2.pop_front();
      chk("sum2", {61'd0, cout2, result2}, {61'd0, e});
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic cy;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    a_in8 = a; b_in8 = b; cin8 = c; start8 = 1;
    @(posedge clk); #1 start8 = 0;
    cy = c;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_shift", busy8, 1);
      chk("done_early", done8, 0);
      chk("add_a", add_a8, a[i]);
      chk("add_b", add_b8, b[i]);
      chk("add_ci", add_ci8, cy);
      cy = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    @(negedge clk);
    chk("done_latency", done8, 1);
    chk("busy_in_done", busy8, 1);
    @(negedge clk);
    chk("done_one_cycle", done8, 0);
    chk("busy_idle", busy8, 0);
  endtask

  initial begin
    int n0;
    #2;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", result8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_add", {add_a8, add_b8, add_ci8}, 0);
    chk("rst_n2", {busy2, done2, cout2, result2, add_a2, add_b2, add_ci2}, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h00, 8'h00, 1'b1);
    // start held high with operands churning; only captured values may matter
    n0 = dq8.size();
    q8.push_back(9'h031);
    a_in8 = 8'h21; b_in8 = 8'h10; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    for (int j = 0; j < 9; j++) begin
      a_in8 = a_in8 + 8'h13;
      b_in8 = b_in8 ^ 8'h5A;
      cin8  = ~cin8;
      @(posedge clk); #1;
    end
    a_in8 = 8'h44; b_in8 = 8'h22; cin8 = 0;
    q8.push_back(9'h066);
    @(posedge clk); #1 start8 = 0;
    for (int t = 0; t < 40 && dq8.size() < n0 + 2; t++) @(negedge clk);
    chk("two_dones", dq8.size() >= n0 + 2, 1);
    if (dq8.size() >= n0 + 2) chk("done_spacing", dq8[n0 + 1] - dq8[n0], 10);
    @(negedge clk);
    // abort in the fourth SHIFT cycle
    a_in8 = 8'h77; b_in8 = 8'h11; cin8 = 0; start8 = 1;
    @(posedge clk); #1 start8 = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_result", result8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_add", {add_a8, add_b8, add_ci8}, 0);
    @(negedge clk) rst = 0;
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_abort", done8, 0);
    end
    op8(8'h12, 8'h34, 1'b0);
    // narrowest width
    q2.push_back(3'b100);
    a_in2 = 2'b11; b_in2 = 2'b01; cin2 = 0; start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("n2_busy", busy2, 1);
      chk("n2_done_early", done2, 0);
      chk("n2_add_a", add_a2, a_in2[i]);
      chk("n2_add_b", add_b2, b_in2[i]);
    end
    @(negedge clk);
    chk("n2_done_latency", done2, 1);
    @(negedge clk);
    chk("n2_idle", {busy2, done2}, 0);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial N-bit adder controller that sits directly upstream of the design's 1-bit mixed RTL/gate full adder, and also consumes that adder's outputs.
- Accepts two N-bit operands and a carry-in, then presents one bit pair per clock (LSB first) to the 1-bit adder.
- Feeds the adder's carry-out back as the next carry-in and assembles the N-bit sum.
- Reports completion with a one-cycle done pulse.

Parameters:
- N, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  N  operand A; captured on the accepted start edge.
- b_in  input  N  operand B; captured on the accepted start edge.
- cin  input  1  initial carry-in; captured on the accepted start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result and cout are valid during it.
- result  output  N  sum, held until the next accepted start.
- cout  output  1  final carry-out, held with result.
- add_a  output  1  bit to the 1-bit adder's a input.
- add_b  output  1  bit to the 1-bit adder's b input.
- add_ci  output  1  carry to the 1-bit adder's ci input.
- add_sum  input  1  sum from the 1-bit adder (combinational).
- add_co  input  1  carry-out from the 1-bit adder (combinational).

Behaviour:
- Reset (async, rst=1): state=IDLE; internal shift registers, carry register and bit counter all cleared.
  - Output values: busy=0, done=0, result=0, cout=0, add_a=add_b=add_ci=0.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted operation; result and cout read 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - add_* outputs driven 0.
  - start=1 at a clock edge loads a_sr<=a_in, b_sr<=b_in, carry_r<=cin, cnt<=0, result_sr<=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - add_a=a_sr[0], add_b=b_sr[0], add_ci=carry_r, combinationally from registers.
  - Each edge: a_sr/b_sr shift right by 1; result_sr<={add_sum, result_sr[N-1:1]}; carry_r<=add_co; cnt<=cnt+1.
  - On the edge where cnt==N-1: move to DONE instead of incrementing. result<={add_sum, result_sr[N-1:1]} and cout<=add_co are registered on that same edge.
- DONE:
  - done=1 for exactly one cycle; add_* driven 0.
  - Next edge returns unconditionally to IDLE.
  - start asserted during DONE is ignored.
- start asserted during SHIFT is ignored; captured operands are not disturbed.
- Latency: start sampled at edge k. SHIFT occupies the N cycles after edge k. done is high in the cycle following edge k+N. busy is high for N+1 cycles.
- Minimum spacing between accepted starts: N+2 edges.
- cnt width is $clog2(N). Arithmetic is modulo 2^N, with the overflow reported only via cout.
- result and cout update only at the SHIFT-to-DONE transition. They are otherwise stable, including while busy for a subsequent operation.
- All outputs are registered or decoded from registered state; there is no combinational path from start to any output.
- add_* depend only on registers, so the adder's combinational loop is broken by carry_r.

Test Plan:
- N=8, a=8'h5A, b=8'h3C, cin=0, 1-cycle start.
  - Required: done after exactly 9 cycles, result=8'h96, cout=0, busy high 9 cycles.
  - Required: add_a/add_b sequence matches operand bits LSB first.
- N=8, a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1.
- N=8, a=8'hFF, b=8'hFF, cin=1 -> result=8'hFF, cout=1.
- N=8, a=8'h00, b=8'h00, cin=1 -> result=8'h01, cout=0.
- start held high continuously from the first accepted start, with a_in changing every cycle.
  - Required: only the first capture is used; the result matches the first operands.
  - Required: the next operation begins on the first IDLE edge (done-to-done spacing N+2).
- rst pulsed at cycle 4 of SHIFT.
  - Required: busy drops asynchronously, no done pulse, result=0, cout=0.
  - Required: a fresh start then completes correctly (8'h12+8'h34 -> 8'h46).
- Re-run with N=2, a=2'b11, b=2'b01, cin=0 -> result=2'b00, cout=1, done 3 cycles after start.
